// File: rtl/decoder_5to32.sv
// 5-to-32 byte-lane select decoder for the cache fill path, with a registered
// copy of the decode and a tracker that flags when every lane of a line was hit.
module decoder_5to32 #(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  sel,
    input  logic        clear,
    output logic [31:0] decOut,
    output logic [31:0] decOutQ,
    output logic [31:0] laneMask,
    output logic        allLanes
);

    localparam logic [31:0] INACTIVE = ACTIVE_LOW ? 32'hFFFF_FFFF : 32'h0000_0000;

    function automatic logic [31:0] lane_onehot(input logic en_i, input logic [4:0] sel_i);
        logic [31:0] r;
        if (en_i) begin
            r = 32'd1 << sel_i;
        end else begin
            r = 32'd0;
        end
        return r;
    endfunction

    logic [31:0] onehot_s;
    logic [31:0] dec_s;
    logic [31:0] dec_out_d;
    logic [31:0] dec_out_q;
    logic [31:0] lane_mask_d;
    logic [31:0] lane_mask_q;

    // Combinational decode with output polarity applied.
    always_comb begin
        onehot_s = lane_onehot(en, sel);
        if (ACTIVE_LOW) begin
            dec_s = ~onehot_s;
        end else begin
            dec_s = onehot_s;
        end
    end

    // Next-state for the decode copy and the lane tracker; the tracker always
    // works on the active-high one-hot so polarity never leaks into it.
    always_comb begin
        dec_out_d   = dec_s;
        lane_mask_d = lane_mask_q;
        if (clear) begin
            lane_mask_d = onehot_s;
        end else begin
            lane_mask_d = lane_mask_q | onehot_s;
        end
    end

    // State registers; reset wins over clear and enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            dec_out_q   <= INACTIVE;
            lane_mask_q <= 32'h0000_0000;
        end else begin
            dec_out_q   <= dec_out_d;
            lane_mask_q <= lane_mask_d;
        end
    end

    assign decOut   = dec_s;
    assign decOutQ  = dec_out_q;
    assign laneMask = lane_mask_q;
    assign allLanes = &lane_mask_q;

endmodule

// File: tb/tb_decoder_5to32.sv
// Self-checking bench for decoder_5to32: directed vector table, hand sequences
// and random traffic, on one instance of each output polarity.
module tb_decoder_5to32;

    logic        clk = 1'b0;
    logic        reset, en, clear;
    logic [4:0]  sel;
    logic [31:0] dec_p, decq_p, mask_p;
    logic [31:0] dec_n, decq_n, mask_n;
    logic        all_p, all_n;

    int checks   = 0;
    int failures = 0;

    bit          seen[32];
    logic [31:0] prev_dec;

    always #5 clk = ~clk;

    decoder_5to32 #(.ACTIVE_LOW(1'b0)) dut_p (
        .clk(clk), .reset(reset), .en(en), .sel(sel), .clear(clear),
        .decOut(dec_p), .decOutQ(decq_p), .laneMask(mask_p), .allLanes(all_p)
    );

    decoder_5to32 #(.ACTIVE_LOW(1'b1)) dut_n (
        .clk(clk), .reset(reset), .en(en), .sel(sel), .clear(clear),
        .decOut(dec_n), .decOutQ(decq_n), .laneMask(mask_n), .allLanes(all_n)
    );

    typedef struct {
        logic        rst;
        logic        clr;
        logic        en;
        logic [4:0]  sel;
        logic [31:0] dec;
        logic [31:0] decq;
        logic [31:0] mask;
        logic        all;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_onehot(input logic e, input logic [4:0] s);
        logic [31:0] r;
        r = 32'h0;
        if (e) r[s] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] ref_mask();
        logic [31:0] m;
        for (int i = 0; i < 32; i++) m[i] = seen[i];
        return m;
    endfunction

    function automatic logic ref_all();
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) if (seen[i]) n++;
        return (n == 32);
    endfunction

    task automatic drive(input logic r, input logic c, input logic e, input logic [4:0] s);
        @(negedge clk);
        reset = r; clear = c; en = e; sel = s;
        #1;
    endtask

    // One cycle checked against the lane-set model.
    task automatic model_cycle(input logic r, input logic c, input logic e, input logic [4:0] s);
        logic [31:0] exp;
        drive(r, c, e, s);
        exp = ref_onehot(e, s);
        chk("dec_hi", dec_p, exp);
        chk("dec_lo", dec_n, ~exp);
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) seen[i] = 1'b0;
            prev_dec = 32'h0;
        end else begin
            if (c) for (int i = 0; i < 32; i++) seen[i] = 1'b0;
            if (e) seen[s] = 1'b1;
            prev_dec = exp;
        end
        #1;
        chk("decq_hi", decq_p, prev_dec);
        chk("decq_lo", decq_n, ~prev_dec);
        chk("mask_hi", mask_p, ref_mask());
        chk("mask_lo", mask_n, ref_mask());
        chk("all_hi", {31'd0, all_p}, {31'd0, ref_all()});
        chk("all_lo", {31'd0, all_n}, {31'd0, ref_all()});
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; en = 1'b0; sel = 5'd0;
        prev_dec = 32'h0;
        for (int i = 0; i < 32; i++) seen[i] = 1'b0;

        //            rst   clr   en    sel    dec           decq          mask          all
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 5'd0,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 5'd3,  32'h0000_0008, 32'h0000_0008, 32'h0000_0008, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 5'd9,  32'h0000_0200, 32'h0000_0200, 32'h0000_0208, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 5'd7,  32'h0000_0000, 32'h0000_0000, 32'h0000_0208, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 5'd4,  32'h0000_0010, 32'h0000_0010, 32'h0000_0010, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 5'd0,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 5'd2,  32'h0000_0004, 32'h0000_0004, 32'h0000_0004, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 5'd2,  32'h0000_0004, 32'h0000_0004, 32'h0000_0004, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 5'd2,  32'h0000_0004, 32'h0000_0004, 32'h0000_0004, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 5'd5,  32'h0000_0020, 32'h0000_0020, 32'h0000_0024, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 5'd6,  32'h0000_0040, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 5'd31, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0};

        for (int v = 0; v < 12; v++) begin
            drive(vecs[v].rst, vecs[v].clr, vecs[v].en, vecs[v].sel);
            chk($sformatf("tbl%0d_dec_hi", v), dec_p, vecs[v].dec);
            chk($sformatf("tbl%0d_dec_lo", v), dec_n, ~vecs[v].dec);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_decq_hi", v), decq_p, vecs[v].decq);
            chk($sformatf("tbl%0d_decq_lo", v), decq_n, ~vecs[v].decq);
            chk($sformatf("tbl%0d_mask_hi", v), mask_p, vecs[v].mask);
            chk($sformatf("tbl%0d_mask_lo", v), mask_n, vecs[v].mask);
            chk($sformatf("tbl%0d_all", v), {31'd0, all_p}, {31'd0, vecs[v].all});
        end

        // Exhaustive decode sweep.
        model_cycle(1'b1, 1'b0, 1'b0, 5'd0);
        for (int i = 0; i < 32; i++) begin
            model_cycle(1'b0, 1'b1, 1'b1, 5'(i));
            chk("onehot_count", 32'($countones(dec_p)), 32'd1);
            chk("onehot_bit", dec_p, 32'd1 << i);
        end

        // Full fill from 31 down to 0.
        model_cycle(1'b1, 1'b0, 1'b1, 5'd17);
        for (int i = 31; i >= 0; i--) begin
            model_cycle(1'b0, 1'b0, 1'b1, 5'(i));
            chk("fill_all", {31'd0, all_p}, {31'd0, (i == 0)});
        end
        chk("fill_mask", mask_p, 32'hFFFF_FFFF);
        model_cycle(1'b0, 1'b0, 1'b0, 5'd3);
        chk("fill_hold", {31'd0, all_p}, 32'd1);
        model_cycle(1'b0, 1'b1, 1'b1, 5'd4);
        chk("clear_mask", mask_p, 32'h0000_0010);
        chk("clear_all", {31'd0, all_p}, 32'd0);

        // Random traffic against the lane-set model.
        for (int k = 0; k < 400; k++) begin
            model_cycle(($urandom_range(0, 63) == 0),
                        ($urandom_range(0, 31) == 0),
                        ($urandom_range(0, 3) != 0),
                        5'($urandom_range(0, 31)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
